// File: rtl/tcdm_subsys_pkg.sv
// Shared types and sizing for the TCDM read-stream sequencer.
// Latency: none (declarations only).
// Backpressure: n/a.
package tcdm_subsys_pkg;

    // TCDM geometry: 8 banks x 64 words x 8 bytes.
    localparam int unsigned NrBanks            = 8;
    localparam int unsigned TCDMDepth          = 64;
    localparam int unsigned DefNarrowDataWidth = 64;
    localparam int unsigned DefTCDMAddrWidth   =
        $clog2(NrBanks * TCDMDepth * DefNarrowDataWidth / 8);

    localparam int unsigned DefMaxOutstanding  = 4;
    localparam int unsigned DefCountWidth      = 16;

    // Width needed to hold a value in 0..n inclusive.
    function automatic int unsigned credit_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

    localparam int unsigned DefCreditWidth = credit_width(DefMaxOutstanding);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/tcdm_stream_fifo.sv
// Synchronous FIFO holding read responses ahead of the output stream.
// Latency: a pushed word is visible on data_o the cycle after the push.
// Backpressure: push ignored when full, pop ignored when empty.
module tcdm_stream_fifo #(
    parameter int unsigned Width = 64,
    parameter int unsigned Depth = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic [Width-1:0]           data_i,
    input  logic                       pop_i,
    output logic [Width-1:0]           data_o,
    output logic [$clog2(Depth+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             push_ok, pop_ok;

    assign full_o  = (cnt_q == CntW'(Depth));
    assign empty_o = (cnt_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = cnt_q;

    // Occupancy tracks push/pop; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        cnt_d = cnt_q;
        unique case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Storage and pointers; Depth is a power of two so pointers wrap naturally.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/tcdm_rd_stream_ctrl.sv
// Issues a strided burst of TCDM reads and streams the responses out in order.
// Latency: start at cycle 0 -> first request cycle 1 -> first stream word cycle 3 (1-cycle TCDM).
// Backpressure: credits (outstanding + buffered <= MaxOutstanding) stop requests when the stream stalls.
module tcdm_rd_stream_ctrl
    import tcdm_subsys_pkg::*;
#(
    parameter int unsigned NarrowDataWidth = DefNarrowDataWidth,
    parameter int unsigned TCDMAddrWidth   = DefTCDMAddrWidth,
    parameter int unsigned MaxOutstanding  = DefMaxOutstanding,
    parameter int unsigned CountWidth      = DefCountWidth
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [TCDMAddrWidth-1:0]     cfg_base_i,
    input  logic [TCDMAddrWidth-1:0]     cfg_stride_i,
    input  logic [CountWidth-1:0]        cfg_count_i,
    input  logic                         start_i,
    output logic                         busy_o,
    output logic                         done_o,
    output logic [TCDMAddrWidth-1:0]     tcdm_req_addr_o,
    output logic                         tcdm_req_write_o,
    output logic [NarrowDataWidth/8-1:0] tcdm_req_strb_o,
    output logic                         tcdm_req_q_valid_o,
    input  logic                         tcdm_rsp_q_ready_i,
    input  logic                         tcdm_rsp_p_valid_i,
    input  logic [NarrowDataWidth-1:0]   tcdm_rsp_data_i,
    output logic [NarrowDataWidth-1:0]   strm_data_o,
    output logic                         strm_valid_o,
    input  logic                         strm_ready_i
);

    localparam int unsigned CrW = credit_width(MaxOutstanding);

    state_e                   state_q, state_d;
    logic [TCDMAddrWidth-1:0] addr_q, addr_d;
    logic [TCDMAddrWidth-1:0] stride_q, stride_d;
    logic [CountWidth-1:0]    remain_q, remain_d;
    logic [CrW-1:0]           outst_q, outst_d;
    logic                     done_q, done_d;

    logic [CrW-1:0]           fifo_cnt;
    logic                     fifo_empty, fifo_full;
    logic                     credit_ok, req_hs, rsp_accept, strm_pop;
    logic                     start_burst, start_empty, drain_idle;

    // A read may only be issued if it has a guaranteed FIFO slot to land in.
    assign credit_ok   = ({1'b0, outst_q} + {1'b0, fifo_cnt}) < (CrW+1)'(MaxOutstanding);
    assign req_hs      = tcdm_req_q_valid_o && tcdm_rsp_q_ready_i;
    // Responses with nothing outstanding (e.g. stragglers from before a reset) are dropped.
    assign rsp_accept  = tcdm_rsp_p_valid_i && (outst_q != '0);
    assign strm_pop    = strm_valid_o && strm_ready_i;
    assign start_burst = (state_q == IDLE) && start_i && (cfg_count_i != '0);
    assign start_empty = (state_q == IDLE) && start_i && (cfg_count_i == '0);
    assign drain_idle  = (outst_q == '0) && fifo_empty && !tcdm_rsp_p_valid_i;

    assign tcdm_req_addr_o  = addr_q;
    assign tcdm_req_write_o = 1'b0;
    assign tcdm_req_strb_o  = '1;
    assign done_o           = done_q;

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: leave ISSUE on the last handshake, leave DRAIN once everything is delivered.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_burst) state_d = ISSUE;
            ISSUE:   if (req_hs && (remain_q == CountWidth'(1))) state_d = DRAIN;
            DRAIN:   if (drain_idle) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: request valid is gated only by credits, so address/valid hold until granted.
    always_comb begin
        busy_o             = (state_q != IDLE);
        tcdm_req_q_valid_o = (state_q == ISSUE) && credit_ok;
    end

    // Burst bookkeeping: latch config on start, advance address and count on each handshake.
    always_comb begin
        addr_d   = addr_q;
        stride_d = stride_q;
        remain_d = remain_q;
        if (start_burst) begin
            addr_d   = cfg_base_i;
            stride_d = cfg_stride_i;
            remain_d = cfg_count_i;
        end else if (req_hs) begin
            addr_d   = addr_q + stride_q;
            remain_d = remain_q - 1'b1;
        end
    end

    // Outstanding-read counter; an issue and a response in the same cycle cancel out.
    always_comb begin
        outst_d = outst_q;
        unique case ({req_hs, rsp_accept})
            2'b10:   outst_d = outst_q + 1'b1;
            2'b01:   outst_d = outst_q - 1'b1;
            default: outst_d = outst_q;
        endcase
    end

    // Completion pulse on the cycle the FSM re-enters IDLE, or right after an empty start.
    always_comb begin
        done_d = start_empty || ((state_q == DRAIN) && drain_idle);
    end

    // Datapath and counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q   <= '0;
            stride_q <= '0;
            remain_q <= '0;
            outst_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            addr_q   <= addr_d;
            stride_q <= stride_d;
            remain_q <= remain_d;
            outst_q  <= outst_d;
            done_q   <= done_d;
        end
    end

    tcdm_stream_fifo #(
        .Width (NarrowDataWidth),
        .Depth (MaxOutstanding)
    ) i_rsp_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (rsp_accept),
        .data_i  (tcdm_rsp_data_i),
        .pop_i   (strm_pop),
        .data_o  (strm_data_o),
        .count_o (fifo_cnt),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign strm_valid_o = !fifo_empty;

    // Protocol checks: no unsolicited responses, and credits keep the FIFO from overflowing.
    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            assert (!(tcdm_rsp_p_valid_i && (outst_q == '0)))
                else $error("tcdm_rd_stream_ctrl: read response with no outstanding request");
            assert (!(rsp_accept && fifo_full))
                else $error("tcdm_rd_stream_ctrl: response arrived with response buffer full");
        end
    end

endmodule

// File: tb/tb_tcdm_rd_stream_ctrl.sv
// Directed bench for tcdm_rd_stream_ctrl with a 1-cycle TCDM responder model.
// Latency: responses return one cycle after each request handshake.
// Backpressure: grant and stream-ready are driven by the directed sequence.
module tb_tcdm_rd_stream_ctrl;

    localparam int unsigned DW = 64;
    localparam int unsigned AW = 12;
    localparam int unsigned CW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] cfg_base = '0;
    logic [AW-1:0] cfg_stride = '0;
    logic [CW-1:0] cfg_count = '0;
    logic          start = 1'b0;
    logic          busy, done;
    logic [AW-1:0] req_addr;
    logic          req_write;
    logic [DW/8-1:0] req_strb;
    logic          q_valid;
    logic          q_ready = 1'b0;
    logic          p_valid = 1'b0;
    logic [DW-1:0] p_data = '0;
    logic [DW-1:0] strm_data;
    logic          strm_valid;
    logic          strm_ready = 1'b0;

    logic [DW-1:0] tmem [512];
    logic [AW-1:0] exp_addr_q [$];
    logic [DW-1:0] exp_data_q [$];

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int hs_cnt   = 0;
    int done_cnt = 0;

    tcdm_rd_stream_ctrl dut (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .cfg_base_i         (cfg_base),
        .cfg_stride_i       (cfg_stride),
        .cfg_count_i        (cfg_count),
        .start_i            (start),
        .busy_o             (busy),
        .done_o             (done),
        .tcdm_req_addr_o    (req_addr),
        .tcdm_req_write_o   (req_write),
        .tcdm_req_strb_o    (req_strb),
        .tcdm_req_q_valid_o (q_valid),
        .tcdm_rsp_q_ready_i (q_ready),
        .tcdm_rsp_p_valid_i (p_valid),
        .tcdm_rsp_data_i    (p_data),
        .strm_data_o        (strm_data),
        .strm_valid_o       (strm_valid),
        .strm_ready_i       (strm_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chk_cnt = chk_cnt + 1;
        assert (obs === exp) pass_cnt = pass_cnt + 1;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one start pulse and records the reads/data this burst must produce.
    task automatic start_burst(input logic [AW-1:0] base, input logic [AW-1:0] stride,
                               input logic [CW-1:0] count);
        logic [AW-1:0] a;
        a = base;
        for (int i = 0; i < int'(count); i++) begin
            exp_addr_q.push_back(a);
            exp_data_q.push_back(tmem[a[11:3]]);
            a = a + stride;
        end
        cfg_base   = base;
        cfg_stride = stride;
        cfg_count  = count;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int limit);
        int n;
        n = 0;
        while (busy && n < limit) begin
            tick();
            n++;
        end
        check(tag, {63'b0, busy}, 64'd0);
    endtask

    // TCDM model: a request granted at a clock edge returns its data one cycle later.
    always begin
        logic          r_hs;
        logic [AW-1:0] r_addr;
        @(negedge clk);
        r_hs   = q_valid && q_ready && rst_n;
        r_addr = req_addr;
        @(posedge clk);
        #2;
        p_valid = r_hs && rst_n;
        p_data  = tmem[r_addr[11:3]];
    end

    // Request monitor: each granted address must be the next one expected.
    always @(negedge clk) begin
        if (rst_n && q_valid && q_ready) begin
            hs_cnt++;
            check("req_pending", {63'b0, exp_addr_q.size() != 0}, 64'd1);
            if (exp_addr_q.size() != 0) begin
                check("req_addr", {52'b0, req_addr}, {52'b0, exp_addr_q.pop_front()});
            end
        end
    end

    // Stream monitor: each accepted word must be the next one expected.
    always @(negedge clk) begin
        if (rst_n && strm_valid && strm_ready) begin
            check("strm_pending", {63'b0, exp_data_q.size() != 0}, 64'd1);
            if (exp_data_q.size() != 0) begin
                check("strm_data", strm_data, exp_data_q.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (done) done_cnt++;
    end

    initial begin
        int h0;
        int d0;
        int n;

        for (int i = 0; i < 512; i++) tmem[i] = 64'hA5A5_0000_0000_0000 | 64'(i);
        for (int i = 0; i < 16; i++)  tmem[i] = 64'h100 + 64'(i);

        // Reset state
        tick();
        tick();
        check("rst_busy",    {63'b0, busy},       64'd0);
        check("rst_done",    {63'b0, done},       64'd0);
        check("rst_qvalid",  {63'b0, q_valid},    64'd0);
        check("rst_svalid",  {63'b0, strm_valid}, 64'd0);
        check("rst_addr",    {52'b0, req_addr},   64'd0);
        check("const_write", {63'b0, req_write},  64'd0);
        check("const_strb",  {56'b0, req_strb},   64'hFF);
        rst_n = 1'b1;
        tick();

        // Basic burst with first-word latency
        q_ready = 1'b1;
        strm_ready = 1'b1;
        d0 = done_cnt;
        start_burst(12'h000, 12'h008, 16'd8);
        check("lat_qvalid_c1", {63'b0, q_valid}, 64'd1);
        check("lat_busy_c1",   {63'b0, busy},    64'd1);
        tick();
        check("lat_svalid_c2", {63'b0, strm_valid}, 64'd0);
        tick();
        check("lat_svalid_c3", {63'b0, strm_valid}, 64'd1);
        check("lat_sdata_c3",  strm_data, 64'h100);
        wait_idle("basic_timeout", 100);
        tick();
        check("basic_done_once", 64'(done_cnt - d0), 64'd1);
        check("basic_busy_low",  {63'b0, busy}, 64'd0);
        check("basic_all_addr",  64'(exp_addr_q.size()), 64'd0);
        check("basic_all_data",  64'(exp_data_q.size()), 64'd0);

        // Backpressure: stalled stream caps the burst at MaxOutstanding reads
        strm_ready = 1'b0;
        h0 = hs_cnt;
        start_burst(12'h000, 12'h008, 16'd16);
        repeat (20) tick();
        check("bp_hs_capped", 64'(hs_cnt - h0), 64'd4);
        check("bp_qvalid_lo", {63'b0, q_valid}, 64'd0);
        check("bp_svalid_hi", {63'b0, strm_valid}, 64'd1);
        strm_ready = 1'b1;
        wait_idle("bp_timeout", 300);
        tick();
        check("bp_hs_total",  64'(hs_cnt - h0), 64'd16);
        check("bp_all_data",  64'(exp_data_q.size()), 64'd0);

        // Stride with address wrap
        start_burst(12'hFF8, 12'h010, 16'd3);
        wait_idle("wrap_timeout", 100);
        tick();
        check("wrap_all_addr", 64'(exp_addr_q.size()), 64'd0);
        check("wrap_all_data", 64'(exp_data_q.size()), 64'd0);

        // Grant stall: request must hold address and valid
        q_ready = 1'b0;
        start_burst(12'h040, 12'h008, 16'd2);
        for (int i = 0; i < 5; i++) begin
            check("stall_qvalid", {63'b0, q_valid}, 64'd1);
            check("stall_addr",   {52'b0, req_addr}, 64'h040);
            tick();
        end
        q_ready = 1'b1;
        wait_idle("stall_timeout", 100);
        tick();
        check("stall_all_data", 64'(exp_data_q.size()), 64'd0);

        // Zero-count start
        d0 = done_cnt;
        start_burst(12'h080, 12'h008, 16'd0);
        check("zero_done_c1",  {63'b0, done},    64'd1);
        check("zero_busy_c1",  {63'b0, busy},    64'd0);
        check("zero_qvalid",   {63'b0, q_valid}, 64'd0);
        tick();
        check("zero_done_c2",  {63'b0, done},    64'd0);

        // Start while busy is ignored
        d0 = done_cnt;
        start_burst(12'h100, 12'h008, 16'd4);
        cfg_base  = 12'h200;
        cfg_count = 16'd8;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        wait_idle("busy_timeout", 100);
        tick();
        repeat (3) tick();
        check("busy_done_once", 64'(done_cnt - d0), 64'd1);
        check("busy_all_addr",  64'(exp_addr_q.size()), 64'd0);
        check("busy_all_data",  64'(exp_data_q.size()), 64'd0);
        check("busy_idle",      {63'b0, busy}, 64'd0);

        // Reset mid-burst after three issues
        h0 = hs_cnt;
        start_burst(12'h000, 12'h008, 16'd8);
        n = 0;
        while ((hs_cnt - h0) < 3 && n < 20) begin
            tick();
            n++;
        end
        check("rmb_three_issues", 64'(hs_cnt - h0), 64'd3);
        rst_n = 1'b0;
        #1;
        check("rmb_busy",   {63'b0, busy},       64'd0);
        check("rmb_done",   {63'b0, done},       64'd0);
        check("rmb_qvalid", {63'b0, q_valid},    64'd0);
        check("rmb_svalid", {63'b0, strm_valid}, 64'd0);
        check("rmb_addr",   {52'b0, req_addr},   64'd0);
        check("rmb_sdata",  strm_data,           64'd0);
        exp_addr_q.delete();
        exp_data_q.delete();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        check("post_rst_svalid", {63'b0, strm_valid}, 64'd0);
        d0 = done_cnt;
        start_burst(12'h008, 12'h008, 16'd4);
        wait_idle("post_rst_timeout", 100);
        tick();
        check("post_rst_done",     64'(done_cnt - d0), 64'd1);
        check("post_rst_all_addr", 64'(exp_addr_q.size()), 64'd0);
        check("post_rst_all_data", 64'(exp_data_q.size()), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
